// File: rtl/sram_arbiter.sv
// Purpose : two-port arbiter/sequencer sharing one 16-bit SRAM MemoryInterface
//           (port 0 = display reader, high priority; port 1 = renderer, rd/wr).
// Latency : req seen at edge t -> o_gntN + strobe in cycle t+1; i_mem_done in
//           cycle k -> o_doneN in cycle k+1; earliest next grant in cycle k+2.
// Backpr. : one transaction in flight; requesters hold req/addr/we/wdata until
//           o_gntN, and further requests simply wait in IDLE arbitration.
//
// Ports:
//   i_clk, i_rst_n                   clock, async active-low reset
//   i_req0/i_addr0 -> o_gnt0/o_done0 port 0 read requester
//   i_req1/i_we1/i_addr1/i_wdata1 -> o_gnt1/o_done1  port 1 requester
//   o_rdata, o_err                   completion data / timeout flag (qualified by o_doneN)
//   o_busy                           state is not IDLE
//   o_mem_read/o_mem_write           one-cycle command strobes
//   o_mem_addr/o_mem_wdata/o_mem_wdata_oe  held address, write data, io_data drive
//   i_mem_rdata/i_mem_done           read-back data and MemoryInterface done
//
// Optional: define ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYC
// cycles; without it WAIT lasts until i_mem_done and o_err stays 0.

module sram_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 16,
  parameter int STARVE_MAX  = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic [ADDR_W-1:0] i_addr0,
  output logic              o_gnt0,
  output logic              o_done0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt1,
  output logic              o_done1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic              o_busy,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_wdata_oe,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_done
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic          port_q;   // 0 = port 0 owns the transaction, 1 = port 1
  logic          we_q;
  logic [SW-1:0] starve_cnt;
  logic          pick1;

  // Port 1 wins when port 0 is idle, or when port 0 has had STARVE_MAX
  // back-to-back grants while port 1 was waiting.
  assign pick1 = i_req1 && (!i_req0 || (starve_cnt == STARVE_LIM));

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout;
  // wait_cnt is 0 in the first WAIT cycle, so the last allowed WAIT cycle is TIMEOUT_CYC-1.
  assign timeout = (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      port_q         <= 1'b0;
      we_q           <= 1'b0;
      starve_cnt     <= '0;
      o_gnt0         <= 1'b0;
      o_gnt1         <= 1'b0;
      o_done0        <= 1'b0;
      o_done1        <= 1'b0;
      o_rdata        <= '0;
      o_err          <= 1'b0;
      o_busy         <= 1'b0;
      o_mem_read     <= 1'b0;
      o_mem_write    <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_wdata    <= '0;
      o_mem_wdata_oe <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt       <= '0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      o_gnt0      <= 1'b0;
      o_gnt1      <= 1'b0;
      o_done0     <= 1'b0;
      o_done1     <= 1'b0;
      o_err       <= 1'b0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;

      case (state)
        IDLE: begin
          if (!i_req1) starve_cnt <= '0;
          if (i_req0 || i_req1) begin
            state  <= ISSUE;
            o_busy <= 1'b1;
            if (pick1) begin
              port_q         <= 1'b1;
              we_q           <= i_we1;
              o_mem_addr     <= i_addr1;
              o_mem_wdata    <= i_wdata1;
              o_gnt1         <= 1'b1;
              o_mem_read     <= !i_we1;
              o_mem_write    <= i_we1;
              o_mem_wdata_oe <= i_we1;
              starve_cnt     <= '0;
            end else begin
              port_q         <= 1'b0;
              we_q           <= 1'b0;
              o_mem_addr     <= i_addr0;
              o_gnt0         <= 1'b1;
              o_mem_read     <= 1'b1;
              o_mem_wdata_oe <= 1'b0;
              if (i_req1 && (starve_cnt != STARVE_LIM)) starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end

        // A done coinciding with the strobe cycle is not ours to act on yet.
        ISSUE: begin
          state <= WAIT;
`ifdef ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        WAIT: begin
          if (i_mem_done) begin
            if (!we_q) o_rdata <= i_mem_rdata;
            o_done0        <= !port_q;
            o_done1        <= port_q;
            o_mem_wdata_oe <= 1'b0;
            o_busy         <= 1'b0;
            state          <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (timeout) begin
            o_rdata        <= '0;
            o_err          <= 1'b1;
            o_done0        <= !port_q;
            o_done1        <= port_q;
            o_mem_wdata_oe <= 1'b0;
            o_busy         <= 1'b0;
            state          <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
